// File: rtl/stepper_pkg.sv
// Shared types and helpers for the stepper pulse generator.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } step_state_e;

  localparam int unsigned DEF_PULSE_W = 8;
  localparam int unsigned DEF_CNT_W   = 32;

  // Increment that sticks at the all-ones value of a width-bit counter (width <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_v) ? max_v : (val + 64'd1);
  endfunction

endpackage

// File: rtl/stepper_pulse_gen_channel.sv
// Single stepper channel: IDLE/HIGH/LOW FSM, phase counter, remaining-step
// counter and issued-step counter. With STEPPER_ENDSTOP_EN defined the
// endstop input passes through a 2-flop synchronizer; otherwise it is ignored.
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned PULSE_W = DEF_PULSE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [CNT_W-1:0] cmd_period,
  input  logic             cmd_dir,
  input  logic             abort,
  input  logic             endstop,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] steps_done
);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] PW_C       = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2 * PULSE_W);

  step_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;          // cycles left in current phase, minus one
  logic [CNT_W-1:0] rem_q, rem_d;          // steps still to issue after the current one
  logic [CNT_W-1:0] low_q, low_d;          // LOW phase length of the active move
  logic [CNT_W-1:0] steps_done_q, steps_done_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] eff_period;
  logic             es_sync;

`ifdef STEPPER_ENDSTOP_EN
  logic es_meta_q, es_meta_d, es_sync_q, es_sync_d;

  // Synchronizer next-state: shift the raw endstop level through two stages.
  always_comb begin
    es_meta_d = endstop;
    es_sync_d = es_meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      es_meta_q <= 1'b0;
      es_sync_q <= 1'b0;
    end else begin
      es_meta_q <= es_meta_d;
      es_sync_q <= es_sync_d;
    end
  end

  assign es_sync = es_sync_q;
`else
  logic endstop_unused;
  assign endstop_unused = endstop;
  assign es_sync        = 1'b0;
`endif

  // Next-state, counter and strobe logic for one channel.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    low_d        = low_q;
    steps_done_d = steps_done_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    eff_period   = (cmd_period > MIN_PERIOD) ? cmd_period : MIN_PERIOD;

    unique case (state_q)
      IDLE: begin
        // A command accepted while idle wins over a held abort; the abort
        // then takes effect from HIGH on the following edge.
        if (accept) begin
          dir_d = cmd_dir;
          low_d = eff_period - PW_C;
          if ((cmd_steps == '0) || es_sync) begin
            steps_done_d = '0;
            done_d       = 1'b1;
          end else begin
            state_d      = HIGH;
            cnt_d        = PW_C - ONE;
            rem_d        = cmd_steps - ONE;
            steps_done_d = CNT_W'(sat_inc(64'd0, CNT_W));
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          if (es_sync) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
            cnt_d   = low_q - ONE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      LOW: begin
        if (abort || es_sync) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          if (rem_q != '0) begin
            state_d      = HIGH;
            cnt_d        = PW_C - ONE;
            rem_d        = rem_q - ONE;
            steps_done_d = CNT_W'(sat_inc(64'(steps_done_q), CNT_W));
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      low_q        <= '0;
      steps_done_q <= '0;
      dir_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      low_q        <= low_d;
      steps_done_q <= steps_done_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
    end
  end

  assign step       = (state_q == HIGH);
  assign busy       = (state_q != IDLE);
  assign dir        = dir_q;
  assign done_pulse = done_q;
  assign steps_done = steps_done_q;

endmodule

// File: rtl/stepper_pulse_gen.sv
// Multi-channel stepper pulse generator: command decode plus NUM_CH
// independent stepper_channel instances. Optional endstop handling is
// enabled by defining STEPPER_ENDSTOP_EN.
module stepper_pulse_gen
  import stepper_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned PULSE_W = DEF_PULSE_W
) (
  input  logic                                         clk_clk,
  input  logic                                         reset_reset_n,
  input  logic                                         cmd_valid,
  output logic                                         cmd_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cmd_ch,
  input  logic [CNT_W-1:0]                             cmd_steps,
  input  logic [CNT_W-1:0]                             cmd_period,
  input  logic                                         cmd_dir,
  input  logic [NUM_CH-1:0]                            abort,
  input  logic [NUM_CH-1:0]                            endstop,
  output logic [NUM_CH-1:0]                            step,
  output logic [NUM_CH-1:0]                            dir,
  output logic [NUM_CH-1:0]                            busy,
  output logic [NUM_CH-1:0]                            done_pulse,
  output logic [NUM_CH*CNT_W-1:0]                      steps_done
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] accept;

  // Ready only for an existing, idle channel; out-of-range channels never match.
  always_comb begin
    cmd_ready = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (cmd_ch == CH_W'(k)) cmd_ready = !busy[k];
    end
  end

  // Route the handshake to the addressed channel.
  always_comb begin
    accept = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      accept[k] = cmd_valid && cmd_ready && (cmd_ch == CH_W'(k));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    stepper_channel #(
      .CNT_W   (CNT_W),
      .PULSE_W (PULSE_W)
    ) u_ch (
      .clk        (clk_clk),
      .rst_n      (reset_reset_n),
      .accept     (accept[g]),
      .cmd_steps  (cmd_steps),
      .cmd_period (cmd_period),
      .cmd_dir    (cmd_dir),
      .abort      (abort[g]),
      .endstop    (endstop[g]),
      .step       (step[g]),
      .dir        (dir[g]),
      .busy       (busy[g]),
      .done_pulse (done_pulse[g]),
      .steps_done (steps_done[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Scoreboard bench for stepper_pulse_gen: commands push expected completions,
// a monitor pops and checks them when done_pulse fires.
module tb_stepper_pulse_gen;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 32;
  localparam int PULSE_W = 8;
  localparam int CH_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      cmd_valid = 1'b0;
  logic                      cmd_ready;
  logic [CH_W-1:0]           cmd_ch = '0;
  logic [CNT_W-1:0]          cmd_steps = '0;
  logic [CNT_W-1:0]          cmd_period = '0;
  logic                      cmd_dir = 1'b0;
  logic [NUM_CH-1:0]         abort = '0;
  logic [NUM_CH-1:0]         endstop = '0;
  logic [NUM_CH-1:0]         step, dir, busy, done_pulse;
  logic [NUM_CH*CNT_W-1:0]   steps_done;

  stepper_pulse_gen #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .PULSE_W (PULSE_W)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_ch        (cmd_ch),
    .cmd_steps     (cmd_steps),
    .cmd_period    (cmd_period),
    .cmd_dir       (cmd_dir),
    .abort         (abort),
    .endstop       (endstop),
    .step          (step),
    .dir           (dir),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .steps_done    (steps_done)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint done_cyc;
    longint steps;
    longint period;
    logic   d;
  } exp_t;

  exp_t   sb_q[NUM_CH][$];
  longint dm[NUM_CH];       // edge at which the channel's last move completes
  longint acc_m[NUM_CH];    // accept edge of the last move
  longint per_m[NUM_CH];    // effective period of the last move
  int     checks = 0;
  int     errors = 0;
  bit     in_reset = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  int   pulses[NUM_CH];
  int   hi_len[NUM_CH];
  int   lo_len[NUM_CH];
  logic prev_step[NUM_CH];

  always @(negedge clk) begin
    if (in_reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        pulses[k] = 0; hi_len[k] = 0; lo_len[k] = 0; prev_step[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (step[k] && !prev_step[k]) begin
          if (sb_q[k].size() == 0) fail_event($sformatf("step_without_cmd_ch%0d", k));
          else if (lo_len[k] != 0)
            check($sformatf("low_len_ch%0d", k), lo_len[k], sb_q[k][0].period - PULSE_W);
          pulses[k]++; hi_len[k] = 1; lo_len[k] = 0;
        end else if (step[k]) begin
          hi_len[k]++;
        end else if (prev_step[k]) begin
          if (sb_q[k].size() != 0 && cyc != sb_q[k][0].done_cyc)
            check($sformatf("high_len_ch%0d", k), hi_len[k], PULSE_W);
          hi_len[k] = 0; lo_len[k] = 1;
        end else if (lo_len[k] != 0) begin
          lo_len[k]++;
        end
        prev_step[k] = step[k];

        if (done_pulse[k]) begin
          if (sb_q[k].size() == 0) fail_event($sformatf("unexpected_done_ch%0d", k));
          else begin
            exp_t e;
            e = sb_q[k].pop_front();
            check($sformatf("done_cycle_ch%0d", k), cyc, e.done_cyc);
            check($sformatf("steps_done_ch%0d", k), steps_done[k*CNT_W +: CNT_W], e.steps);
            check($sformatf("pulse_count_ch%0d", k), pulses[k], e.steps);
            check($sformatf("dir_ch%0d", k), dir[k], e.d);
            check($sformatf("busy_at_done_ch%0d", k), busy[k], 0);
          end
          pulses[k] = 0; hi_len[k] = 0; lo_len[k] = 0;
        end else if (sb_q[k].size() != 0 && cyc > sb_q[k][0].done_cyc) begin
          fail_event($sformatf("done_missing_ch%0d", k));
          void'(sb_q[k].pop_front());
          pulses[k] = 0; hi_len[k] = 0; lo_len[k] = 0;
        end
      end
    end
  end

  // ---------------- driver helpers (called at a falling edge) ----------------
  task automatic send_cmd(input int ch, input longint steps, input longint period, input logic d);
    longint c, n, p;
    bit     exp_rdy;
    exp_t   e;
    c       = cyc;
    exp_rdy = (c >= dm[ch]);
    cmd_ch     = CH_W'(ch);
    cmd_steps  = CNT_W'(steps);
    cmd_period = CNT_W'(period);
    cmd_dir    = d;
    cmd_valid  = 1'b1;
    #1;
    check($sformatf("cmd_ready_ch%0d", ch), cmd_ready, exp_rdy);
    if (exp_rdy) begin
      n = c + 1;
      p = (period > 2 * PULSE_W) ? period : 2 * PULSE_W;
      e.done_cyc = (steps == 0) ? n : n + steps * p;
      e.steps    = steps;
      e.period   = p;
      e.d        = d;
      sb_q[ch].push_back(e);
      dm[ch] = e.done_cyc; acc_m[ch] = n; per_m[ch] = p;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Abort sampled at edge a: steps started strictly before a survive.
  task automatic model_abort(input int ch, input longint a);
    int     idx;
    longint s;
    idx = sb_q[ch].size() - 1;
    if (idx >= 0 && a > acc_m[ch] && a <= sb_q[ch][idx].done_cyc) begin
      s = (a - acc_m[ch] + per_m[ch] - 1) / per_m[ch];
      if (s < sb_q[ch][idx].steps) sb_q[ch][idx].steps = s;
      sb_q[ch][idx].done_cyc = a;
      dm[ch] = a;
    end
  endtask

  task automatic wait_until(input longint target, input string name);
    for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
    if (cyc < target) fail_event(name);
  endtask

  task automatic wait_idle(input int ch);
    wait_until(dm[ch], $sformatf("wait_idle_timeout_ch%0d", ch));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    longint n;
    int     idx;
    for (int k = 0; k < NUM_CH; k++) begin dm[k] = 0; acc_m[k] = 0; per_m[k] = 16; end

    #12;
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_pulse, 0);
    check("rst_steps_done_zero", (steps_done == '0), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 in_reset = 1'b0;
    @(negedge clk);

    // Single move 3 x 20, then clamped period 2 x 5 (-> 16)
    send_cmd(0, 3, 20, 1'b1);
    check("single_move_done_edge", dm[0] - acc_m[0], 60);
    wait_idle(0);
    send_cmd(0, 2, 5, 1'b0);
    check("clamp_done_edge", dm[0] - acc_m[0], 32);
    wait_idle(0);

    // Zero steps: never busy
    send_cmd(1, 0, 50, 1'b1);
    check("zero_steps_busy0", busy[1], 0);
    @(negedge clk);
    check("zero_steps_busy1", busy[1], 0);

    // Abort in the HIGH phase of step 10, then a command under a held abort
    send_cmd(2, 100, 20, 1'b0);
    n = acc_m[2];
    wait_until(n + 9 * 20 + 2, "abort_wait");
    abort[2] = 1'b1;
    model_abort(2, cyc + 1);
    @(negedge clk);
    #1;
    check("abort_step_low", step[2], 0);
    check("abort_busy_low", busy[2], 0);
    send_cmd(2, 5, 20, 1'b1);
    model_abort(2, acc_m[2] + 1);
    @(negedge clk);
    abort[2] = 1'b0;
    wait_idle(2);

    // Endstop raised mid-LOW after step 5
    send_cmd(1, 8, 20, 1'b0);
    n = acc_m[1];
    wait_until(n + 4 * 20 + 12, "endstop_wait");
    endstop[1] = 1'b1;
`ifdef STEPPER_ENDSTOP_EN
    idx = sb_q[1].size() - 1;
    if (idx >= 0) begin
      sb_q[1][idx].steps    = 5;
      sb_q[1][idx].done_cyc = cyc + 3;
      dm[1] = cyc + 3;
    end
    wait_idle(1);
    send_cmd(1, 4, 20, 1'b1);
    idx = sb_q[1].size() - 1;
    if (idx >= 0) begin
      sb_q[1][idx].steps    = 0;
      sb_q[1][idx].done_cyc = acc_m[1];
      dm[1] = acc_m[1];
    end
`else
    idx = 0;
`endif
    wait_idle(1);
    endstop = '0;
    repeat (3) @(negedge clk);

    // Randomized traffic with backpressure and occasional aborts
    for (int it = 0; it < 400; it++) begin
      int r;
      int ch;
      r  = $urandom_range(0, 9);
      ch = $urandom_range(0, NUM_CH - 1);
`ifndef STEPPER_ENDSTOP_EN
      endstop = NUM_CH'($urandom);
`endif
      if (r < 6) begin
        send_cmd(ch, $urandom_range(0, 4), $urandom_range(0, 30), 1'($urandom));
      end else if (r == 6 && cyc >= acc_m[ch] && cyc < dm[ch]) begin
        abort[ch] = 1'b1;
        model_abort(ch, cyc + 1);
        @(negedge clk);
        abort[ch] = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    endstop = '0;
    for (int k = 0; k < NUM_CH; k++) wait_idle(k);
    @(negedge clk);
    for (int k = 0; k < NUM_CH; k++) check($sformatf("sb_empty_ch%0d", k), sb_q[k].size(), 0);

    // Concurrency and backpressure
    send_cmd(0, 10, 20, 1'b1);
    send_cmd(3, 10, 20, 1'b0);
    @(negedge clk);
    send_cmd(0, 1, 20, 1'b0);
    wait_idle(0);
    wait_idle(3);

    // Reset mid-move
    send_cmd(0, 10, 20, 1'b1);
    send_cmd(3, 5, 30, 1'b1);
    repeat (50) @(negedge clk);
    #2;
    in_reset = 1'b1;
    for (int k = 0; k < NUM_CH; k++) sb_q[k].delete();
    rst_n = 1'b0;
    #1;
    check("midrst_step", step, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done_pulse, 0);
    check("midrst_dir", dir, 0);
    check("midrst_steps_done_zero", (steps_done == '0), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 in_reset = 1'b0;
    for (int k = 0; k < NUM_CH; k++) dm[k] = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_done", done_pulse, 0);
      check("post_rst_busy", busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
